// File: rtl/fdsyncr_bank_pkg.sv
// Shared definitions for the fdsyncr_bank load/sync register bank.
package jag_sync_pkg;

  localparam int MAX_STAGES = 4;
  localparam int LANE_W     = 8;

  typedef struct packed {
    logic [LANE_W-1:0] data;
    logic              tag;
  } lane_tag_t;

  function automatic int lane_slice(input int idx, input int width = LANE_W);
    return idx * width;
  endfunction

endpackage

// File: rtl/fdsyncr_bank_if.sv
// Lane data, load, freeze and delivery signals of the fdsyncr_bank.
interface fdsyncr_bank_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);

  logic [CHANNELS*WIDTH-1:0] d;
  logic [CHANNELS-1:0]       ld;
  logic                      frz;
  logic [CHANNELS*WIDTH-1:0] q;
  logic [CHANNELS-1:0]       upd;
  logic                      busy;

  modport master (output d, ld, frz, input q, upd, busy);
  modport slave  (input d, ld, frz, output q, upd, busy);

endinterface

// File: rtl/fdsyncr_bank_lane.sv
// One lane: capture register, frz-stallable delay pipeline, update tag and strobe.
// Build option FDSYNCR_CHG_DETECT_EN: only loads that change the captured value raise an update.
module fdsyncr_lane
  import jag_sync_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             ld,
  input  logic             frz,
  output logic [WIDTH-1:0] q,
  output logic             upd,
  output logic             busy
);

  // Out-of-range depths are clamped to the supported 1..MAX_STAGES.
  localparam int DEPTH = (STAGES < 1) ? 1 : ((STAGES > MAX_STAGES) ? MAX_STAGES : STAGES);

  logic [WIDTH-1:0] cap;
  logic             set_tag;

`ifdef FDSYNCR_CHG_DETECT_EN
  assign set_tag = ld && (d != cap);
`else
  assign set_tag = ld;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap <= RST_VAL;
    end else if (ld) begin
      cap <= d;
    end
  end

  if (DEPTH == 1) begin : g_direct
    logic upd_r;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        upd_r <= 1'b0;
      end else begin
        upd_r <= set_tag;
      end
    end

    assign q    = cap;
    assign upd  = upd_r;
    assign busy = 1'b0;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH-1];
    logic [DEPTH-1:0] tag;

    // tag[0] belongs to the capture stage; the top tag bit doubles as the upd strobe.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < DEPTH - 1; k++) begin
          stage[k] <= RST_VAL;
        end
        tag <= '0;
      end else begin
        tag[0] <= set_tag | (tag[0] & frz);
        if (!frz) begin
          stage[0] <= cap;
          for (int k = 1; k < DEPTH - 1; k++) begin
            stage[k] <= stage[k-1];
          end
          tag[DEPTH-1:1] <= tag[DEPTH-2:0];
        end else begin
          tag[DEPTH-1] <= 1'b0;
        end
      end
    end

    assign q    = stage[DEPTH-2];
    assign upd  = tag[DEPTH-1];
    assign busy = |tag[DEPTH-2:0];
  end

endmodule

// File: rtl/fdsyncr_bank.sv
// Bank of CHANNELS independent load/sync lanes sharing one freeze control.
// Build option FDSYNCR_CHG_DETECT_EN is handled inside each lane.
module fdsyncr_bank
  import jag_sync_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               CHANNELS = 4,
  parameter int               STAGES   = 2,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input logic           clk,
  input logic           rst,
  fdsyncr_bank_if.slave bus
);

  logic [CHANNELS*WIDTH-1:0] q_all;
  logic [CHANNELS-1:0]       upd_all;
  logic [CHANNELS-1:0]       busy_all;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    localparam int OFS = lane_slice(i, WIDTH);

    fdsyncr_lane #(
      .WIDTH   (WIDTH),
      .STAGES  (STAGES),
      .RST_VAL (RST_VAL)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .d    (bus.d[OFS +: WIDTH]),
      .ld   (bus.ld[i]),
      .frz  (bus.frz),
      .q    (q_all[OFS +: WIDTH]),
      .upd  (upd_all[i]),
      .busy (busy_all[i])
    );
  end

  assign bus.q    = q_all;
  assign bus.upd  = upd_all;
  assign bus.busy = |busy_all;

endmodule

// File: tb/tb_fdsyncr_bank.sv
// Self-checking bench for fdsyncr_bank (WIDTH=8, CHANNELS=4, STAGES=2); honours FDSYNCR_CHG_DETECT_EN.
module tb_fdsyncr_bank;
  import jag_sync_pkg::*;

  localparam int W = 8;
  localparam int C = 4;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  fdsyncr_bank_if #(.WIDTH(W), .CHANNELS(C)) bus ();

  fdsyncr_bank #(.WIDTH(W), .CHANNELS(C), .STAGES(2), .RST_VAL('0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [C-1:0]   ld;
    logic [C*W-1:0] d;
    logic           frz;
    logic [C*W-1:0] q;
    logic [C-1:0]   upd;
    logic           busy;
  } vec_t;

  vec_t vecs [14];

  // Reference state: each lane holds its captured value plus a pending-update flag.
  lane_tag_t    m_cap [C];
  logic [W-1:0] m_q   [C];
  logic [C-1:0] m_upd;
  logic         m_busy;

  task automatic apply_stimulus(input logic [C-1:0] ld, input logic [C*W-1:0] d, input logic frz);
    bus.ld  = ld;
    bus.d   = d;
    bus.frz = frz;
  endtask

  task automatic check_output(input string name, input logic [C*W-1:0] exp_q,
                              input logic [C-1:0] exp_upd, input logic exp_busy);
    total++;
    if (bus.q === exp_q && bus.upd === exp_upd && bus.busy === exp_busy) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got q=%h upd=%b busy=%b, want q=%h upd=%b busy=%b",
               name, bus.q, bus.upd, bus.busy, exp_q, exp_upd, exp_busy);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < C; i++) begin
      m_cap[i] = '{data: '0, tag: 1'b0};
      m_q[i]   = '0;
    end
    m_upd  = '0;
    m_busy = 1'b0;
  endtask

  // One clock edge: an unfrozen edge delivers the captured value and any pending update.
  task automatic model_step(input logic [C-1:0] ld, input logic [C*W-1:0] d, input logic frz);
    logic [W-1:0] din;
    logic         chg;
    m_busy = 1'b0;
    for (int i = 0; i < C; i++) begin
      din = d[i*W +: W];
`ifdef FDSYNCR_CHG_DETECT_EN
      chg = (din != m_cap[i].data);
`else
      chg = 1'b1;
`endif
      if (!frz) begin
        m_q[i]   = m_cap[i].data;
        m_upd[i] = m_cap[i].tag;
      end else begin
        m_upd[i] = 1'b0;
      end
      m_cap[i].tag = (ld[i] && chg) || (m_cap[i].tag && frz);
      if (ld[i]) m_cap[i].data = din;
      m_busy = m_busy | m_cap[i].tag;
    end
  endtask

  function automatic logic [C*W-1:0] model_q();
    logic [C*W-1:0] r;
    for (int i = 0; i < C; i++) r[i*W +: W] = m_q[i];
    return r;
  endfunction

  initial begin
    logic [C-1:0]   rld;
    logic [C*W-1:0] rd;
    logic           rfrz;

    passed = 0;
    total  = 0;

    // Latency, coalescing, simultaneous load and same-value writes.
    vecs[0]  = '{4'b0001, 32'h0000_00A5, 1'b0, 32'h0000_0000, 4'b0000, 1'b1};
    vecs[1]  = '{4'b0000, 32'h0000_0000, 1'b0, 32'h0000_00A5, 4'b0001, 1'b0};
    vecs[2]  = '{4'b0000, 32'h0000_0000, 1'b0, 32'h0000_00A5, 4'b0000, 1'b0};
    vecs[3]  = '{4'b0010, 32'h0000_1100, 1'b1, 32'h0000_00A5, 4'b0000, 1'b1};
    vecs[4]  = '{4'b0010, 32'h0000_2200, 1'b1, 32'h0000_00A5, 4'b0000, 1'b1};
    vecs[5]  = '{4'b0010, 32'h0000_3300, 1'b1, 32'h0000_00A5, 4'b0000, 1'b1};
    vecs[6]  = '{4'b0000, 32'h0000_0000, 1'b0, 32'h0000_33A5, 4'b0010, 1'b0};
    vecs[7]  = '{4'b0000, 32'h0000_0000, 1'b0, 32'h0000_33A5, 4'b0000, 1'b0};
    vecs[8]  = '{4'b1111, 32'h4433_2211, 1'b0, 32'h0000_33A5, 4'b0000, 1'b1};
    vecs[9]  = '{4'b0000, 32'h0000_0000, 1'b0, 32'h4433_2211, 4'b1111, 1'b0};
    vecs[10] = '{4'b0000, 32'h0000_0000, 1'b0, 32'h4433_2211, 4'b0000, 1'b0};
    vecs[11] = '{4'b0100, 32'h005A_0000, 1'b0, 32'h4433_2211, 4'b0000, 1'b1};
`ifdef FDSYNCR_CHG_DETECT_EN
    vecs[12] = '{4'b0100, 32'h005A_0000, 1'b0, 32'h445A_2211, 4'b0100, 1'b0};
    vecs[13] = '{4'b0000, 32'h0000_0000, 1'b0, 32'h445A_2211, 4'b0000, 1'b0};
`else
    vecs[12] = '{4'b0100, 32'h005A_0000, 1'b0, 32'h445A_2211, 4'b0100, 1'b1};
    vecs[13] = '{4'b0000, 32'h0000_0000, 1'b0, 32'h445A_2211, 4'b0100, 1'b0};
`endif

    rst = 1'b1;
    apply_stimulus('0, '0, 1'b0);
    repeat (2) @(negedge clk);
    check_output("reset_state", '0, '0, 1'b0);
    rst = 1'b0;

    for (int v = 0; v < 14; v++) begin
      apply_stimulus(vecs[v].ld, vecs[v].d, vecs[v].frz);
      @(negedge clk);
      check_output($sformatf("vec%0d", v), vecs[v].q, vecs[v].upd, vecs[v].busy);
    end

    // Mid-pipeline reset acts immediately and drops the in-flight update.
    apply_stimulus(4'b0001, 32'h0000_0077, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_output("async_reset", '0, '0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus('0, '0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_output($sformatf("post_reset%0d", c), '0, '0, 1'b0);
    end

    // Lane 3 streams a wrapping count; q3 trails d3 by one edge with upd3 held high.
    for (int c = 0; c < 260; c++) begin
      logic [W-1:0] prev;
      prev = W'(c - 1);
      apply_stimulus(4'b1000, {W'(c), 24'h0}, 1'b0);
      @(negedge clk);
      if (c >= 1) begin
        total++;
        if (bus.q[3*W +: W] === prev && bus.upd[3] === 1'b1) begin
          passed++;
        end else begin
          $display("[TB] FAIL stream%0d: got q3=%h upd3=%b, want q3=%h upd3=1",
                   c, bus.q[3*W +: W], bus.upd[3], prev);
        end
      end
    end

    // Randomized traffic against the reference model, starting from a clean reset.
    apply_stimulus('0, '0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 400; c++) begin
      rld  = C'($urandom);
      rd   = $urandom;
      if ($urandom_range(0, 3) == 0) rd[2*W +: W] = m_cap[2].data;
      rfrz = ($urandom_range(0, 3) == 0);
      apply_stimulus(rld, rd, rfrz);
      model_step(rld, rd, rfrz);
      @(negedge clk);
      check_output($sformatf("rand%0d", c), model_q(), m_upd, m_busy);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
